uart_tx_fifo: RTL and testbench

- Byte FIFO plus launch sequencer that sits directly upstream of the UART transmitter.
- Accepts bytes from the CPU/bus side at any rate and issues them one at a time over the transmitter's data/start/busy handshake.
- Holds the byte under transmission stable in a dedicated register for the whole frame. This is required because the transmitter samples its data input bit by bit, live, throughout the frame.

---
 rtl/uart_tx_fifo.sv | 72 +++++++
 tb/tb_uart_tx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO and launch sequencer feeding a UART transmitter over a start/busy handshake.
// Define UART_TX_FIFO_OVERFLOW_EN to add a sticky overflow flag with overflow_clr.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  idle
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic                  overflow,
  input  logic                  overflow_clr
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;
  localparam logic [ADDR_WIDTH:0] L_FULL = DEPTH[ADDR_WIDTH:0];
  logic [7:0]            r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [7:0]            r_tx_data;
  logic                  r_tx_start;
  state_t                r_state, w_state_nxt;
  logic                  w_wr, w_pop;
  assign full     = r_count == L_FULL;
  assign empty    = r_count == '0;
  assign count    = r_count;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign idle     = empty && r_state == S_IDLE && !tx_busy;
  assign w_wr     = wr_en && !full;
  always_ff @(posedge clk)
    r_state <= rst ? S_IDLE : w_state_nxt;
  always_comb
    w_state_nxt = r_state == S_IDLE      ? (empty   ? S_IDLE      : S_WAIT_BUSY) :
                  r_state == S_WAIT_BUSY ? (tx_busy ? S_WAIT_DONE : S_WAIT_BUSY) :
                                           (tx_busy ? S_WAIT_DONE : S_IDLE);
  always_comb
    w_pop = r_state == S_IDLE && !empty;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  // tx_data only reloads on a pop, so it is frozen for the whole frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + {{(ADDR_WIDTH-1){1'b0}}, w_wr};
      r_rd_ptr   <= r_rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, w_pop};
      r_count    <= r_count + {{ADDR_WIDTH{1'b0}}, w_wr} - {{ADDR_WIDTH{1'b0}}, w_pop};
      r_tx_data  <= w_pop ? r_mem[r_rd_ptr] : r_tx_data;
      r_tx_start <= w_pop;
    end
  end
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic r_overflow;
  assign overflow = r_overflow;
  always_ff @(posedge clk)
    r_overflow <= rst ? 1'b0 : (wr_en && full) ? 1'b1 : overflow_clr ? 1'b0 : r_overflow;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with a simple transmitter model.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       tx_busy = 1'b0;
  logic       full, empty, tx_start, idle;
  logic [4:0] count;
  logic [7:0] tx_data;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic       overflow;
  logic       overflow_clr = 1'b0;
`endif
  logic       hold = 1'b0;
  logic [7:0] cur = 8'h00;
  int         busy_cnt = 0;
  int         n_chk = 0, n_err = 0;
  int         n_starts = 0, n_sb = 0, n_chg = 0, max_cnt = 0;
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .idle(idle)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    , .overflow(overflow), .overflow_clr(overflow_clr)
`endif
  );

  always #5 clk = ~clk;

  // transmitter: busy one cycle after start, held 20 cycles unless hold is set
  always @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_start && !tx_busy) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 20;
      cur      <= tx_data;
      rx.push_back(tx_data);
    end else if (tx_busy && !hold) begin
      if (busy_cnt == 1) tx_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (tx_start) n_starts++;
    if (tx_start && tx_busy) n_sb++;
    if (tx_busy && tx_data !== cur) n_chg++;
    if (int'(count) > max_cnt) max_cnt = int'(count);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    exp_q.push_back(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (!idle && k < lim) begin
      tick();
      k++;
    end
    chk("idle_wait", {31'd0, idle}, 32'd1);
  endtask

  task automatic start_test();
    rx.delete();
    exp_q.delete();
    n_starts = 0;
    n_sb = 0;
    n_chg = 0;
    max_cnt = 0;
  endtask

  task automatic cmp_rx(input string tag);
    chk({tag, "_n"}, rx.size(), exp_q.size());
    foreach (exp_q[i])
      chk($sformatf("%s_%0d", tag, i), i < rx.size() ? {24'd0, rx[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    start_test();
    repeat (10) tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_txdata", tx_data, 8'h00);
    chk("rst_idle", idle, 1);
    chk("rst_starts", n_starts, 0);

    start_test();
    push(8'h55);
    chk("lat_n_start", tx_start, 0);
    chk("lat_n_count", count, 1);
    tick();
    chk("lat_n1_start", tx_start, 1);
    chk("lat_n1_data", tx_data, 8'h55);
    chk("lat_n1_count", count, 0);
    tick();
    chk("lat_n2_start", tx_start, 0);
    chk("lat_n2_busy", tx_busy, 1);
    wait_idle(200);
    cmp_rx("single");
    chk("single_starts", n_starts, 1);
    chk("single_chg", n_chg, 0);
    chk("single_count", count, 0);
    chk("single_hold", tx_data, 8'h55);

    start_test();
    for (int i = 1; i <= 5; i++) push(8'(i));
    wait_idle(1000);
    cmp_rx("burst");
    chk("burst_starts", n_starts, 5);
    chk("burst_sb", n_sb, 0);
    chk("burst_chg", n_chg, 0);

    start_test();
    hold = 1'b1;
    push(8'h10);
    repeat (3) tick();
    chk("fill_first", tx_data, 8'h10);
    for (int i = 0; i < 15; i++) push(8'h20 + 8'(i));
    chk("fill15_count", count, 15);
    chk("fill15_full", full, 0);
    push(8'h2F);
    chk("fill16_count", count, 16);
    chk("fill16_full", full, 1);
    wr_data = 8'hAA;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    chk("drop_count", count, 16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("ovf_set", overflow, 1);
    tick();
    chk("ovf_sticky", overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
`endif
    hold = 1'b0;
    wait_idle(2000);
    cmp_rx("fill");
    chk("fill_starts", n_starts, 17);
    chk("fill_sb", n_sb, 0);
    chk("fill_chg", n_chg, 0);
    chk("fill_no_aa", {31'd0, rx.size() > 0 && (8'hAA inside {rx})}, 0);

    start_test();
    begin
      int idx = 0;
      int cyc = 0;
      while ((idx < 40 || !idle) && cyc < 5000) begin
        if (idx < 40 && !full && cyc % 5 == 0) begin
          wr_data = 8'(idx);
          wr_en   = 1'b1;
          exp_q.push_back(8'(idx));
          idx++;
        end
        tick();
        wr_en = 1'b0;
        cyc++;
      end
      chk("wrap_done", {31'd0, idle && idx == 40}, 1);
    end
    cmp_rx("wrap");
    chk("wrap_max", {31'd0, max_cnt > 16}, 0);
    chk("wrap_reached_full", max_cnt, 16);
    chk("wrap_sb", n_sb, 0);
    chk("wrap_chg", n_chg, 0);

    start_test();
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    repeat (5) tick();
    chk("mid_busy", tx_busy, 1);
    chk("mid_count", count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_start", tx_start, 0);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_idle", idle, 1);
    repeat (60) tick();
    chk("mid_rx_n", rx.size(), 1);
    chk("mid_starts", n_starts, 1);
    chk("mid_idle_after", idle, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
